// File: rtl/stdp_synapse.sv
// Presynaptic weight bank feeding lif.current, with trace-based pair STDP; current and weights update 1 cycle after inputs.
// No backpressure: every input is sampled on every clock edge.
module stdp_synapse #(
    parameter int N_PRE     = 4,
    parameter int AW        = 2,
    parameter int W_INIT    = 32,
    parameter int A_PLUS    = 4,
    parameter int A_MINUS   = 2,
    parameter int TRACE_WIN = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_PRE-1:0] pre_spike,
    input  logic             post_spike,
    input  logic             learn_en,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [7:0]       wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [7:0]       rd_data,
    output logic [7:0]       current
);

    logic [7:0]        weight    [N_PRE];
    logic [7:0]        weight_nxt[N_PRE];
    logic [2:0]        pre_trace [N_PRE];
    logic [2:0]        post_trace;
    logic signed [9:0] w_sum     [N_PRE];
    logic [10:0]       cur_sum;
    logic [7:0]        cur_nxt;

    always_comb begin
        cur_sum = '0;
        for (int i = 0; i < N_PRE; i++) begin
            if (pre_spike[i]) cur_sum = cur_sum + 11'(weight[i]);
        end
        cur_nxt = (cur_sum > 11'd255) ? 8'd255 : cur_sum[7:0];
    end

    // Potentiation and depression may both fire; the net step is clamped once.
    always_comb begin
        for (int i = 0; i < N_PRE; i++) begin
            w_sum[i] = $signed({2'b00, weight[i]});
            if (learn_en && post_spike && pre_trace[i] != 3'd0)
                w_sum[i] = w_sum[i] + 10'(A_PLUS);
            if (learn_en && pre_spike[i] && post_trace != 3'd0)
                w_sum[i] = w_sum[i] - 10'(A_MINUS);
            if (w_sum[i][9])
                weight_nxt[i] = 8'd0;
            else if (w_sum[i][8])
                weight_nxt[i] = 8'd255;
            else
                weight_nxt[i] = w_sum[i][7:0];
            if (wr_en && wr_addr == AW'(i))
                weight_nxt[i] = wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N_PRE; i++) begin
            if (rd_addr == AW'(i)) rd_data = weight[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_PRE; i++) begin
                weight[i]    <= 8'(W_INIT);
                pre_trace[i] <= '0;
            end
            post_trace <= '0;
            current    <= '0;
        end else begin
            for (int i = 0; i < N_PRE; i++) begin
                weight[i] <= weight_nxt[i];
                if (pre_spike[i])
                    pre_trace[i] <= 3'(TRACE_WIN);
                else if (pre_trace[i] != 3'd0)
                    pre_trace[i] <= pre_trace[i] - 3'd1;
            end
            if (post_spike)
                post_trace <= 3'(TRACE_WIN);
            else if (post_trace != 3'd0)
                post_trace <= post_trace - 3'd1;
            current <= cur_nxt;
        end
    end

endmodule
